chip_model_core: RTL and testbench
==================================

# chip_model_core

Parametrised behavioural model of the test chip's datapath. It replaces the fixed 64-byte/512-byte emulator with configurable data width, buffer depths, compute latency and arithmetic mode. It sits behind the activation and weight SPI slaves in the simulation chip model and consumes their byte-valid streams. It returns results on the activation channel and reports status and error flags to the bench.

## Interface
Parameters:
- DATA_W, 8, activation/weight/result width (unsigned)
- ACT_DEPTH, 64, activation buffer entries; also number of results
- W_DEPTH, 512, weight buffer entries; must be ≥ ACT_DEPTH
- COMP_CYCLES, 1000, cycles spent in COMP; must be ≥ ACT_DEPTH
- MODE, 0, 0 = result[i] = act[i] + w[i]; 1 = result[i] = act[i] × w[i]

Ports:
- CLK_100M  in  1  clock
- rst_n  in  1  reset; synchronous, active-low, clock CLK_100M
- start_mapw  in  1  weight-mapping trigger, sampled every cycle
- start_calc  in  1  calculation trigger, sampled every cycle
- act_rx_valid  in  1  one-cycle pulse, byte received on activation SPI
- act_rx_data  in  DATA_W  received activation byte
- w_rx_valid  in  1  one-cycle pulse, byte received on weight SPI
- w_rx_data  in  DATA_W  received weight byte
- act_tx_valid  out  1  level, result byte available for SPI slave TX
- act_tx_data  out  DATA_W  result byte to serialise
- busy  out  1  high in MAP, COMP and SPI
- done  out  1  one-cycle pulse when the last result has been read
- state  out  2  current state encoding
- err_ovf  out  1  sticky: a write arrived to a full act/weight buffer

## Operation
- States: IDLE(0), MAP(1), COMP(2), SPI(3). Reset enters IDLE.
- Transitions:
  - IDLE→MAP on start_mapw.
  - MAP→COMP on start_calc.
  - COMP→SPI when the cycle counter reaches COMP_CYCLES-1.
  - SPI→IDLE when tx_idx reaches ACT_DEPTH.
- Triggers are ignored in all other states. start_calc in IDLE is ignored. If start_mapw and start_calc are both high in IDLE, the block goes to MAP only.
- Activation capture: in IDLE and MAP only, act_rx_valid writes act_buf[act_idx] and increments act_idx.
- Weight capture: in IDLE and MAP only, w_rx_valid writes w_buf[w_idx] and increments w_idx.
- Full buffers: a write with act_idx==ACT_DEPTH or w_idx==W_DEPTH is dropped and sets err_ovf. Indices never wrap.
- COMP: element counter e computes one result per cycle (result[e] from act_buf[e] and w_buf[e]) for e = 0..ACT_DEPTH-1, then idles until the cycle count expires. w_buf entries ≥ ACT_DEPTH are stored but unused.
- Arithmetic: unsigned, full-width intermediate (DATA_W+1 bits for add, 2·DATA_W bits for mul), reduced to DATA_W per Configuration.
- SPI:
  - act_tx_valid=1 and act_tx_data=result[tx_idx], registered.
  - Each act_rx_valid pulse is a read clock: it increments tx_idx and is not stored.
  - When tx_idx==ACT_DEPTH: go to IDLE, pulse done, clear act_idx, w_idx, tx_idx and the cycle counter, and drive act_tx_valid=0, act_tx_data=0.
- err_ovf is cleared only by reset.

## Timing
- Reset values: act_tx_valid=0, act_tx_data=0, busy=0, done=0, state=0, err_ovf=0. All indices and counters are 0 and results are all 0. act_buf and w_buf are not reset.
- Reset mid-operation returns to IDLE in one cycle and discards any partial results.
- COMP occupies exactly COMP_CYCLES cycles. SPI is entered on the cycle after count COMP_CYCLES-1.
- act_tx_data reflects a new tx_idx one cycle after the act_rx_valid pulse.
- A trigger is acted on at the clock edge where it is sampled high. Multi-cycle triggers are harmless because of the state gating.
- done is asserted in the first IDLE cycle after SPI.

## Configuration
- CHIP_MODEL_SAT_EN defined: results clamp to 2^DATA_W-1 on overflow.
- CHIP_MODEL_SAT_EN undefined: results wrap modulo 2^DATA_W.

## Structure
- chip_model_pkg holds:
  - the state encoding constants (ST_IDLE, ST_MAP, ST_COMP, ST_SPI)
  - the mode constants (MODE_ADD, MODE_MUL)
- Sub-module chip_model_alu: combinational, parametrised by DATA_W and MODE. It takes one act/weight pair and produces the DATA_W result. The saturation/wrap choice lives here under CHIP_MODEL_SAT_EN.

## Test plan
- MODE=0: load act[i]=i and w[i]=2i for 64 entries, then start_mapw and start_calc. After exactly 1000 COMP cycles, 64 read pulses return 3i, then done pulses once and state=0.
- MODE=0, act[0]=200, w[0]=100: result is 255 with CHIP_MODEL_SAT_EN and 44 without.
- MODE=1, act[5]=16, w[5]=20: result is 255 with the macro and 64 without. act[1]=3, w[1]=7 gives 21 in both builds.
- Send 65 activation bytes: err_ovf=1, the 65th byte is dropped, and act_buf[63] keeps the 64th value.
- Assert start_calc in IDLE: state stays 0. Assert start_mapw and start_calc together: state becomes 1 only.
- Pulse rst_n low during SPI after 10 reads: state=0, act_tx_valid=0, busy=0, err_ovf=0. A full rerun then produces correct results from index 0.

Source files
------------

// File: rtl/chip_model_pkg.sv
// Shared definitions for the chip datapath model.
// Holds the FSM state encoding and the arithmetic mode selectors.
// Imported by chip_model_alu and chip_model_core.
package chip_model_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAP  = 2'd1,
        ST_COMP = 2'd2,
        ST_SPI  = 2'd3
    } state_e;

    localparam int MODE_ADD = 0;
    localparam int MODE_MUL = 1;

endpackage

// File: rtl/chip_model_alu.sv
// Combinational element operator: one activation/weight pair in, one DATA_W result out.
// Ports: act_i, w_i (DATA_W operands), res_o (DATA_W result).
// Macro CHIP_MODEL_SAT_EN: clamp to all-ones on overflow; otherwise wrap modulo 2^DATA_W.
module chip_model_alu
    import chip_model_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int MODE   = MODE_ADD
) (
    input  logic [DATA_W-1:0] act_i,
    input  logic [DATA_W-1:0] w_i,
    output logic [DATA_W-1:0] res_o
);

    if (MODE == MODE_MUL) begin : g_mul
`ifdef CHIP_MODEL_SAT_EN
        logic [2*DATA_W-1:0] prod;
        assign prod  = {{DATA_W{1'b0}}, act_i} * {{DATA_W{1'b0}}, w_i};
        assign res_o = (|prod[2*DATA_W-1:DATA_W]) ? {DATA_W{1'b1}} : prod[DATA_W-1:0];
`else
        // DATA_W-wide context keeps exactly the low bits of the full product.
        assign res_o = act_i * w_i;
`endif
    end else begin : g_add
`ifdef CHIP_MODEL_SAT_EN
        logic [DATA_W:0] sum;
        assign sum   = {1'b0, act_i} + {1'b0, w_i};
        assign res_o = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
`else
        assign res_o = act_i + w_i;
`endif
    end

endmodule

// File: rtl/chip_model_core.sv
// Behavioural datapath model: capture act/weight byte streams, compute ACT_DEPTH results, stream them back.
// Ports: CLK_100M/rst_n (sync, active-low); start_mapw/start_calc triggers; act/w rx byte-valid streams;
//        act_tx_valid/act_tx_data result stream; busy, done, state, err_ovf status. Macro: CHIP_MODEL_SAT_EN.
module chip_model_core
    import chip_model_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ACT_DEPTH   = 64,
    parameter int W_DEPTH     = 512,
    parameter int COMP_CYCLES = 1000,
    parameter int MODE        = MODE_ADD
) (
    input  logic              CLK_100M,
    input  logic              rst_n,
    input  logic              start_mapw,
    input  logic              start_calc,
    input  logic              act_rx_valid,
    input  logic [DATA_W-1:0] act_rx_data,
    input  logic              w_rx_valid,
    input  logic [DATA_W-1:0] w_rx_data,
    output logic              act_tx_valid,
    output logic [DATA_W-1:0] act_tx_data,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state,
    output logic              err_ovf
);

    // Index counters carry one extra value so "full" (== depth) is representable.
    localparam int AIW = $clog2(ACT_DEPTH + 1);
    localparam int AAW = (ACT_DEPTH > 1) ? $clog2(ACT_DEPTH) : 1;
    localparam int WIW = $clog2(W_DEPTH + 1);
    localparam int WAW = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1;
    localparam int CW  = (COMP_CYCLES > 1) ? $clog2(COMP_CYCLES) : 1;

    localparam logic [AIW-1:0] ACT_FULL = AIW'(ACT_DEPTH);
    localparam logic [WIW-1:0] W_FULL   = WIW'(W_DEPTH);
    localparam logic [CW-1:0]  CYC_LAST = CW'(COMP_CYCLES - 1);

    state_e            state_q, state_d;
    logic [AIW-1:0]    act_idx_q, tx_idx_q, e_q, tx_nxt;
    logic [WIW-1:0]    w_idx_q;
    logic [CW-1:0]     cyc_q;
    logic              busy_q, done_q, err_ovf_q, act_tx_valid_q;
    logic [DATA_W-1:0] act_tx_data_q;
    logic [DATA_W-1:0] res_q   [ACT_DEPTH];
    logic [DATA_W-1:0] act_buf [ACT_DEPTH];
    logic [DATA_W-1:0] w_buf   [W_DEPTH];
    logic [DATA_W-1:0] alu_res;
    logic              cap_en, act_full, w_full, act_we, w_we;

    assign cap_en   = (state_q == ST_IDLE) || (state_q == ST_MAP);
    assign act_full = (act_idx_q == ACT_FULL);
    assign w_full   = (w_idx_q == W_FULL);
    assign act_we   = rst_n && cap_en && act_rx_valid && !act_full;
    assign w_we     = rst_n && cap_en && w_rx_valid && !w_full;
    assign tx_nxt   = tx_idx_q + AIW'(1);

    chip_model_alu #(
        .DATA_W (DATA_W),
        .MODE   (MODE)
    ) u_alu (
        .act_i (act_buf[e_q[AAW-1:0]]),
        .w_i   (w_buf[WAW'(e_q)]),
        .res_o (alu_res)
    );

    // Capture buffers hold raw data only; their contents are never reset.
    always_ff @(posedge CLK_100M) begin
        if (act_we) act_buf[act_idx_q[AAW-1:0]] <= act_rx_data;
        if (w_we)   w_buf[w_idx_q[WAW-1:0]]     <= w_rx_data;
    end

    // start_mapw has priority in IDLE simply because start_calc is not looked at there.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_mapw)            state_d = ST_MAP;
            ST_MAP:  if (start_calc)            state_d = ST_COMP;
            ST_COMP: if (cyc_q == CYC_LAST)     state_d = ST_SPI;
            ST_SPI:  if (tx_idx_q == ACT_FULL)  state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_100M) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            act_idx_q      <= '0;
            w_idx_q        <= '0;
            tx_idx_q       <= '0;
            e_q            <= '0;
            cyc_q          <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_ovf_q      <= 1'b0;
            act_tx_valid_q <= 1'b0;
            act_tx_data_q  <= '0;
            for (int i = 0; i < ACT_DEPTH; i++) res_q[i] <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= 1'b0;

            if (cap_en && act_rx_valid) begin
                if (act_full) err_ovf_q <= 1'b1;
                else          act_idx_q <= act_idx_q + AIW'(1);
            end
            if (cap_en && w_rx_valid) begin
                if (w_full) err_ovf_q <= 1'b1;
                else        w_idx_q   <= w_idx_q + WIW'(1);
            end

            if (state_q == ST_COMP) begin
                // One element per cycle, then idle until the cycle budget runs out.
                if (e_q != ACT_FULL) begin
                    res_q[e_q[AAW-1:0]] <= alu_res;
                    e_q                 <= e_q + AIW'(1);
                end
                if (state_d == ST_SPI) begin
                    cyc_q          <= '0;
                    act_tx_valid_q <= 1'b1;
                    act_tx_data_q  <= res_q[0];
                end else begin
                    cyc_q <= cyc_q + CW'(1);
                end
            end

            if (state_q == ST_SPI) begin
                if (state_d == ST_IDLE) begin
                    done_q    <= 1'b1;
                    act_idx_q <= '0;
                    w_idx_q   <= '0;
                    tx_idx_q  <= '0;
                    e_q       <= '0;
                    cyc_q     <= '0;
                end else if (act_rx_valid) begin
                    // Reads act as the SPI read clock; the byte itself is discarded.
                    tx_idx_q <= tx_nxt;
                    if (tx_nxt == ACT_FULL) begin
                        act_tx_valid_q <= 1'b0;
                        act_tx_data_q  <= '0;
                    end else begin
                        act_tx_data_q <= res_q[tx_nxt[AAW-1:0]];
                    end
                end
            end
        end
    end

    assign act_tx_valid = act_tx_valid_q;
    assign act_tx_data  = act_tx_data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign state        = state_q;
    assign err_ovf      = err_ovf_q;

endmodule

// File: tb/tb_chip_model_core.sv
// Bench for chip_model_core: one add-mode and one mul-mode instance driven by the same streams.
// Expected values come from a vector table plus a small reference for the default ramp data.
// Checks are made #1 after the rising edge; inputs are driven at the same point.
module tb_chip_model_core;

    localparam int DW = 8;
    localparam int AD = 64;
    localparam int WD = 512;
    localparam int CC = 1000;

    logic          CLK_100M = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_mapw = 1'b0, start_calc = 1'b0;
    logic          act_rx_valid = 1'b0, w_rx_valid = 1'b0;
    logic [DW-1:0] act_rx_data = '0, w_rx_data = '0;

    logic          tx_valid0, busy0, done0, err0;
    logic          tx_valid1, busy1, done1, err1;
    logic [DW-1:0] tx_data0, tx_data1;
    logic [1:0]    state0, state1;

    always #5 CLK_100M = ~CLK_100M;

    chip_model_core #(.DATA_W(DW), .ACT_DEPTH(AD), .W_DEPTH(WD), .COMP_CYCLES(CC), .MODE(0)) u_add (
        .CLK_100M(CLK_100M), .rst_n(rst_n), .start_mapw(start_mapw), .start_calc(start_calc),
        .act_rx_valid(act_rx_valid), .act_rx_data(act_rx_data),
        .w_rx_valid(w_rx_valid), .w_rx_data(w_rx_data),
        .act_tx_valid(tx_valid0), .act_tx_data(tx_data0), .busy(busy0), .done(done0),
        .state(state0), .err_ovf(err0));

    chip_model_core #(.DATA_W(DW), .ACT_DEPTH(AD), .W_DEPTH(WD), .COMP_CYCLES(CC), .MODE(1)) u_mul (
        .CLK_100M(CLK_100M), .rst_n(rst_n), .start_mapw(start_mapw), .start_calc(start_calc),
        .act_rx_valid(act_rx_valid), .act_rx_data(act_rx_data),
        .w_rx_valid(w_rx_valid), .w_rx_data(w_rx_data),
        .act_tx_valid(tx_valid1), .act_tx_data(tx_data1), .busy(busy1), .done(done1),
        .state(state1), .err_ovf(err1));

    typedef struct {
        int            idx;
        logic [DW-1:0] a;
        logic [DW-1:0] w;
        logic [DW-1:0] e_add;
        logic [DW-1:0] e_mul;
    } vec_t;

    vec_t          vecs[6];
    logic [DW-1:0] act_v[AD], w_v[AD], exp_add[AD], exp_mul[AD];
    int            n_run = 0;
    int            n_fail = 0;

    task automatic tick();
        @(posedge CLK_100M);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    function automatic logic [DW-1:0] mul_ref(input int a, input int b);
        int p;
        p = a * b;
`ifdef CHIP_MODEL_SAT_EN
        if (p > 255) p = 255;
`endif
        return DW'(p);
    endfunction

    task automatic set_ramp();
        for (int i = 0; i < AD; i++) begin
            act_v[i]   = DW'(i);
            w_v[i]     = DW'(2 * i);
            exp_add[i] = DW'(3 * i);
            exp_mul[i] = mul_ref(i, 2 * i);
        end
    endtask

    task automatic send_act(input logic [DW-1:0] b);
        act_rx_data = b; act_rx_valid = 1'b1; tick(); act_rx_valid = 1'b0; tick();
    endtask

    task automatic send_w(input logic [DW-1:0] b);
        w_rx_data = b; w_rx_valid = 1'b1; tick(); w_rx_valid = 1'b0; tick();
    endtask

    task automatic load_all();
        for (int i = 0; i < AD; i++) send_act(act_v[i]);
        for (int i = 0; i < AD; i++) send_w(w_v[i]);
    endtask

    // From IDLE or MAP, trigger the calculation and measure the time spent in COMP.
    task automatic run_to_spi();
        int cnt;
        if (state0 == 2'd0) begin
            start_mapw = 1'b1; tick(); start_mapw = 1'b0;
        end
        start_calc = 1'b1; tick(); start_calc = 1'b0;
        cnt = 0;
        while (state0 == 2'd2 && cnt < 2 * CC) begin
            cnt++;
            tick();
        end
        chk("comp_cycles", cnt, CC);
        chk("state_spi", state0, 3);
        chk("busy_spi", busy0, 1);
    endtask

    task automatic read_n(input int n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("tx_valid[%0d]", i), tx_valid0, 1);
            chk($sformatf("add_res[%0d]", i), tx_data0, exp_add[i]);
            chk($sformatf("mul_res[%0d]", i), tx_data1, exp_mul[i]);
            act_rx_data = 8'h5A; act_rx_valid = 1'b1; tick(); act_rx_valid = 1'b0; tick();
        end
    endtask

    task automatic finish_run();
        int dcnt;
        dcnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (done0) dcnt++;
            if (k == 0) chk("done_first_idle", done0, 1);
            tick();
        end
        chk("done_pulses", dcnt, 1);
        chk("state_idle_end", state0, 0);
        chk("tx_valid_end", tx_valid0, 0);
        chk("tx_data_end", tx_data0, 0);
        chk("busy_end", busy0, 0);
        chk("mul_state_end", state1, 0);
    endtask

    initial begin
        // Corner vectors, hand-computed for both arithmetic builds.
`ifdef CHIP_MODEL_SAT_EN
        vecs[0] = '{idx: 0,  a: 200, w: 100, e_add: 255, e_mul: 255};
        vecs[2] = '{idx: 5,  a: 16,  w: 20,  e_add: 36,  e_mul: 255};
        vecs[3] = '{idx: 10, a: 255, w: 1,   e_add: 255, e_mul: 255};
        vecs[5] = '{idx: 63, a: 63,  w: 126, e_add: 189, e_mul: 255};
`else
        vecs[0] = '{idx: 0,  a: 200, w: 100, e_add: 44,  e_mul: 32};
        vecs[2] = '{idx: 5,  a: 16,  w: 20,  e_add: 36,  e_mul: 64};
        vecs[3] = '{idx: 10, a: 255, w: 1,   e_add: 0,   e_mul: 255};
        vecs[5] = '{idx: 63, a: 63,  w: 126, e_add: 189, e_mul: 2};
`endif
        vecs[1] = '{idx: 1,  a: 3,   w: 7,   e_add: 10,  e_mul: 21};
        vecs[4] = '{idx: 32, a: 0,   w: 0,   e_add: 0,   e_mul: 0};

        // Reset state.
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
        chk("rst_state", state0, 0);
        chk("rst_tx_valid", tx_valid0, 0);
        chk("rst_tx_data", tx_data0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_err", err0, 0);

        // Run A: ramp data, trigger gating, exact COMP length.
        set_ramp();
        load_all();
        chk("a_err_clean", err0, 0);
        start_calc = 1'b1; tick(); start_calc = 1'b0;
        chk("calc_in_idle", state0, 0);
        start_mapw = 1'b1; start_calc = 1'b1; tick(); start_mapw = 1'b0; start_calc = 1'b0;
        chk("both_trig", state0, 1);
        tick();
        chk("both_trig_hold", state0, 1);
        chk("busy_map", busy0, 1);
        run_to_spi();
        read_n(AD);
        finish_run();

        // Run B: table vectors plus activation overflow.
        set_ramp();
        for (int k = 0; k < 6; k++) begin
            act_v[vecs[k].idx]   = vecs[k].a;
            w_v[vecs[k].idx]     = vecs[k].w;
            exp_add[vecs[k].idx] = vecs[k].e_add;
            exp_mul[vecs[k].idx] = vecs[k].e_mul;
        end
        load_all();
        chk("b_err_before", err0, 0);
        send_act(8'hEE);
        chk("b_err_ovf", err0, 1);
        chk("b_err_ovf_mul", err1, 1);
        run_to_spi();
        read_n(AD);
        finish_run();
        chk("b_err_sticky", err0, 1);

        // Run C: reset in the middle of the SPI phase, then a clean rerun.
        set_ramp();
        load_all();
        run_to_spi();
        read_n(10);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("c_rst_state", state0, 0);
        chk("c_rst_tx_valid", tx_valid0, 0);
        chk("c_rst_busy", busy0, 0);
        chk("c_rst_err", err0, 0);
        chk("c_rst_tx_data", tx_data0, 0);
        load_all();
        run_to_spi();
        read_n(AD);
        finish_run();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
